tlul_fuzz_host: RTL and testbench

- Parametrised TL-UL host sequencer for fuzzing harnesses. It replaces direct fuzzer-driven tl_i in DUT wrappers such as kmac.
- Accepts a compact command stream from the fuzzer and issues legal TL-UL A-channel requests, with up to MaxOutstanding in flight.
- Tracks source IDs, buffers D-channel responses in order of arrival, and flags timeouts.
- Sits between the fuzz input decoder and the DUT's tl_i/tl_o.

---
 rtl/tlul_fuzz_pkg.sv | 73 +++++++
 rtl/prim_fifo_sync.sv | 53 +++++
 rtl/tlul_fuzz_src_alloc.sv | 51 +++++
 rtl/tlul_fuzz_host.sv | 215 +++++++++++++++++++++
 tb/tb_tlul_fuzz_host.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tlul_fuzz_pkg.sv
// rtl/tlul_fuzz_pkg.sv - Types and constants shared by the TL-UL fuzz host sequencer
package tlul_fuzz_pkg;

   localparam logic [1:0] FixedSize       = 2'd2;
   localparam logic [2:0] TlGet           = 3'd4;
   localparam logic [2:0] TlPutFull       = 3'd0;
   localparam logic [2:0] TlPutPartial    = 3'd1;
   localparam logic [2:0] TlAccessAck     = 3'd0;
   localparam logic [2:0] TlAccessAckData = 3'd1;

   typedef enum logic [1:0] {
      OpGet        = 2'd0,
      OpPutFull    = 2'd1,
      OpPutPartial = 2'd2,
      OpWait       = 2'd3
   } cmd_op_e;

   typedef enum logic [1:0] {
      StIdle,
      StIssue,
      StWait,
      StHang
   } host_state_e;

   typedef struct packed {
      cmd_op_e     op;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  mask;
   } cmd_t;

   typedef struct packed {
      logic        err;
      logic        is_read;
      logic [31:0] rdata;
   } rsp_t;

   typedef struct packed {
      logic        a_valid;
      logic [2:0]  a_opcode;
      logic [1:0]  a_size;
      logic [7:0]  a_source;
      logic [31:0] a_address;
      logic [3:0]  a_mask;
      logic [31:0] a_data;
      logic        d_ready;
   } tl_h2d_t;

   typedef struct packed {
      logic        d_valid;
      logic [2:0]  d_opcode;
      logic [1:0]  d_size;
      logic [7:0]  d_source;
      logic [31:0] d_data;
      logic        d_error;
      logic        a_ready;
   } tl_d2h_t;

   function automatic logic [2:0] cmd_opcode(input cmd_op_e op);
      case (op)
         OpGet:        return TlGet;
         OpPutPartial: return TlPutPartial;
         default:      return TlPutFull;
      endcase
   endfunction

   // Only partial puts carry the fuzzer's mask; an empty mask would be illegal, so it becomes byte 0.
   function automatic logic [3:0] cmd_mask(input cmd_t c);
      if (c.op == OpPutPartial) return (c.mask == 4'h0) ? 4'h1 : c.mask;
      return 4'hF;
   endfunction

endpackage

// File: rtl/prim_fifo_sync.sv
// rtl/prim_fifo_sync.sv - Synchronous valid/ready FIFO with arbitrary depth
module prim_fifo_sync #(
   parameter int Width = 8,
   parameter int Depth = 4
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             wvalid_i,
   output logic             wready_o,
   input  logic [Width-1:0] wdata_i,
   output logic             rvalid_o,
   input  logic             rready_i,
   output logic [Width-1:0] rdata_o
);
   localparam int PtrW = $clog2(Depth);
   localparam int CntW = $clog2(Depth + 1);

   logic [Width-1:0] r_mem [Depth];
   logic [PtrW-1:0]  r_wptr;
   logic [PtrW-1:0]  r_rptr;
   logic [CntW-1:0]  r_cnt;
   logic             w_push;
   logic             w_pop;

   assign wready_o = (r_cnt != CntW'(Depth));
   assign rvalid_o = (r_cnt != '0);
   assign rdata_o  = r_mem[r_rptr];
   assign w_push   = wvalid_i && wready_o;
   assign w_pop    = rready_i && rvalid_o;

   function automatic logic [PtrW-1:0] ptr_next(input logic [PtrW-1:0] p);
      return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
   endfunction

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_cnt  <= '0;
      end else begin
         if (w_push) r_wptr <= ptr_next(r_wptr);
         if (w_pop)  r_rptr <= ptr_next(r_rptr);
         r_cnt <= r_cnt + CntW'(w_push) - CntW'(w_pop);
      end
   end

   // Storage needs no reset; occupancy gates every read.
   always_ff @(posedge clk_i) begin
      if (w_push) r_mem[r_wptr] <= wdata_i;
   end

endmodule

// File: rtl/tlul_fuzz_src_alloc.sv
// rtl/tlul_fuzz_src_alloc.sv - Source ID bitmap with lowest-free allocation and in-flight count
module tlul_fuzz_src_alloc #(
   parameter  int N    = 4,
   localparam int SrcW = (N > 1) ? $clog2(N) : 1,
   localparam int CntW = $clog2(N) + 1
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            set_i,
   input  logic [SrcW-1:0] set_id_i,
   input  logic            clr_i,
   input  logic [7:0]      clr_id_i,
   output logic [N-1:0]    map_o,
   output logic [SrcW-1:0] free_id_o,
   output logic            full_o,
   output logic [CntW-1:0] count_o
);
   logic [N-1:0]    r_map;
   logic [N-1:0]    w_set_mask;
   logic [N-1:0]    w_clr_mask;
   logic [SrcW-1:0] w_free;
   logic [CntW-1:0] w_cnt;

   // Decode set/clear masks, find the lowest clear bit and count the set bits.
   always_comb begin
      w_set_mask = '0;
      w_clr_mask = '0;
      w_free     = '0;
      w_cnt      = '0;
      for (int i = 0; i < N; i++) begin
         if (set_i && (set_id_i == SrcW'(i))) w_set_mask[i] = 1'b1;
         if (clr_i && (clr_id_i == 8'(i)))    w_clr_mask[i] = 1'b1;
         w_cnt = w_cnt + CntW'(r_map[i]);
      end
      for (int i = N - 1; i >= 0; i--) begin
         if (!r_map[i]) w_free = SrcW'(i);
      end
   end

   // A response and a new request may touch different IDs in the same cycle.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) r_map <= '0;
      else         r_map <= (r_map & ~w_clr_mask) | w_set_mask;
   end

   assign map_o     = r_map;
   assign free_id_o = w_free;
   assign full_o    = &r_map;
   assign count_o   = w_cnt;

endmodule

// File: rtl/tlul_fuzz_host.sv
// rtl/tlul_fuzz_host.sv - TL-UL host sequencer for fuzz harnesses (option: TLUL_FUZZ_HOST_CHECK_EN)
module tlul_fuzz_host
   import tlul_fuzz_pkg::*;
#(
   parameter  int MaxOutstanding = 4,
   parameter  int CmdDepth       = 4,
   parameter  int RspDepth       = 4,
   parameter  int TimeoutCycles  = 1024,
   localparam int SrcW           = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1,
   localparam int OutW           = $clog2(MaxOutstanding) + 1,
   localparam int StallW         = $clog2(TimeoutCycles + 1)
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            cmd_valid_i,
   output logic            cmd_ready_o,
   input  cmd_t            cmd_i,
   output tl_h2d_t         tl_o,
   input  tl_d2h_t         tl_i,
   output logic            rsp_valid_o,
   input  logic            rsp_ready_i,
   output rsp_t            rsp_o,
   output logic [OutW-1:0] outstanding_o,
   output logic [31:0]     txn_cnt_o,
   output logic            timeout_o,
   output logic            proto_err_o
);
   host_state_e         r_state;
   logic                r_live;
   logic                r_a_valid;
   logic [2:0]          r_a_opcode;
   logic [31:0]         r_a_addr;
   logic [31:0]         r_a_data;
   logic [3:0]          r_a_mask;
   logic [SrcW-1:0]     r_a_source;
   logic [7:0]          r_wait_cnt;
   logic [StallW-1:0]   r_stall;
   logic [31:0]         r_txn_cnt;
   logic                r_timeout;

   cmd_t                w_head;
   rsp_t                w_rsp_wdata;
   logic                w_cmd_rvalid;
   logic                w_cmd_wready;
   logic                w_cmd_pop;
   logic                w_rsp_wready;
   logic                w_a_fire;
   logic                w_d_ready;
   logic                w_d_fire;
   logic                w_err;
   logic                w_full;
   logic                w_stall_hit;
   logic                w_wait_done;
   logic [MaxOutstanding-1:0] w_map;
   logic [SrcW-1:0]     w_free_id;
   logic [OutW-1:0]     w_outstanding;

   // Ready outputs stay low until the first clock after reset release.
   assign cmd_ready_o = w_cmd_wready & r_live;
   assign w_d_ready   = w_rsp_wready & r_live;
   assign w_d_fire    = tl_i.d_valid & w_d_ready;
   assign w_a_fire    = r_a_valid & tl_i.a_ready;
   assign w_stall_hit = (r_stall == StallW'(TimeoutCycles));
   assign w_wait_done = (r_state == StWait) && (r_wait_cnt == 8'd0) && (w_outstanding == '0);
   assign w_cmd_pop   = w_a_fire | w_wait_done;
   assign w_rsp_wdata = {w_err, (tl_i.d_opcode == TlAccessAckData), tl_i.d_data};

   prim_fifo_sync #(.Width($bits(cmd_t)), .Depth(CmdDepth)) u_cmd_fifo (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .wvalid_i (cmd_valid_i & r_live),
      .wready_o (w_cmd_wready),
      .wdata_i  (cmd_i),
      .rvalid_o (w_cmd_rvalid),
      .rready_i (w_cmd_pop),
      .rdata_o  (w_head)
   );

   prim_fifo_sync #(.Width($bits(rsp_t)), .Depth(RspDepth)) u_rsp_fifo (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .wvalid_i (w_d_fire),
      .wready_o (w_rsp_wready),
      .wdata_i  (w_rsp_wdata),
      .rvalid_o (rsp_valid_o),
      .rready_i (rsp_ready_i),
      .rdata_o  (rsp_o)
   );

   tlul_fuzz_src_alloc #(.N(MaxOutstanding)) u_src_alloc (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .set_i     (w_a_fire),
      .set_id_i  (r_a_source),
      .clr_i     (w_d_fire),
      .clr_id_i  (tl_i.d_source),
      .map_o     (w_map),
      .free_id_o (w_free_id),
      .full_o    (w_full),
      .count_o   (w_outstanding)
   );

   // Sequencer: a_valid is only raised with a free ID in hand and is held until accepted, even in Hang.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state    <= StIdle;
         r_a_valid  <= 1'b0;
         r_a_opcode <= '0;
         r_a_addr   <= '0;
         r_a_data   <= '0;
         r_a_mask   <= '0;
         r_a_source <= '0;
         r_wait_cnt <= '0;
         r_timeout  <= 1'b0;
      end else begin
         if (w_a_fire) r_a_valid <= 1'b0;
         if (w_stall_hit) begin
            r_state   <= StHang;
            r_timeout <= 1'b1;
         end else begin
            case (r_state)
               StIdle: begin
                  if (w_cmd_rvalid) begin
                     if (w_head.op == OpWait) begin
                        r_wait_cnt <= w_head.data[7:0];
                        r_state    <= StWait;
                     end else if (!w_full) begin
                        r_a_valid  <= 1'b1;
                        r_a_opcode <= cmd_opcode(w_head.op);
                        r_a_addr   <= {w_head.addr[31:2], 2'b00};
                        r_a_data   <= (w_head.op == OpGet) ? 32'h0 : w_head.data;
                        r_a_mask   <= cmd_mask(w_head);
                        r_a_source <= w_free_id;
                        r_state    <= StIssue;
                     end
                  end
               end
               StIssue: if (w_a_fire) r_state <= StIdle;
               StWait: begin
                  if (r_wait_cnt != 8'd0)  r_wait_cnt <= r_wait_cnt - 8'd1;
                  else if (w_wait_done)    r_state    <= StIdle;
               end
               default: ;
            endcase
         end
      end
   end

   // Stall counter, completed-transaction counter and post-reset enable.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_live    <= 1'b0;
         r_stall   <= '0;
         r_txn_cnt <= '0;
      end else begin
         r_live <= 1'b1;
         if (w_d_fire || (w_outstanding == '0)) r_stall <= '0;
         else if (!w_stall_hit)                 r_stall <= r_stall + 1'b1;
         if (w_d_fire && (r_txn_cnt != 32'hFFFF_FFFF)) r_txn_cnt <= r_txn_cnt + 32'd1;
      end
   end

`ifdef TLUL_FUZZ_HOST_CHECK_EN
   logic [MaxOutstanding-1:0] r_is_get;
   logic                      r_proto_err;
   logic                      w_src_ok;
   logic                      w_bad;
   logic [2:0]                w_exp_op;

   assign w_src_ok = (tl_i.d_source < 8'(MaxOutstanding)) && w_map[tl_i.d_source[SrcW-1:0]];
   assign w_exp_op = r_is_get[tl_i.d_source[SrcW-1:0]] ? TlAccessAckData : TlAccessAck;
   assign w_bad    = !w_src_ok || (tl_i.d_opcode != w_exp_op) || (tl_i.d_size != FixedSize);
   assign w_err    = tl_i.d_error | w_bad;
   assign proto_err_o = r_proto_err;

   // Remember each request's type and latch any malformed response.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_is_get    <= '0;
         r_proto_err <= 1'b0;
      end else begin
         if (w_a_fire) r_is_get[r_a_source] <= (r_a_opcode == TlGet);
         if (w_d_fire && w_bad) r_proto_err <= 1'b1;
      end
   end

   a_valid_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (tl_o.a_valid && !tl_i.a_ready) |=> tl_o.a_valid);
   outstanding_max: assert property (@(posedge clk_i) disable iff (!rst_ni)
      w_outstanding <= OutW'(MaxOutstanding));
`else
   logic w_unused_d;
   assign w_unused_d  = ^{tl_i.d_size, w_map};
   assign w_err       = tl_i.d_error;
   assign proto_err_o = 1'b0;
`endif

   // Registered A fields and the live D-ready drive the DUT-facing bus.
   always_comb begin
      tl_o           = '0;
      tl_o.a_valid   = r_a_valid;
      tl_o.a_opcode  = r_a_opcode;
      tl_o.a_size    = FixedSize;
      tl_o.a_source  = 8'(r_a_source);
      tl_o.a_address = r_a_addr;
      tl_o.a_mask    = r_a_mask;
      tl_o.a_data    = r_a_data;
      tl_o.d_ready   = w_d_ready;
   end

   assign outstanding_o = w_outstanding;
   assign txn_cnt_o     = r_txn_cnt;
   assign timeout_o     = r_timeout;

endmodule

// File: tb/tb_tlul_fuzz_host.sv
// tb/tb_tlul_fuzz_host.sv - Directed self-checking bench for tlul_fuzz_host
module tb_tlul_fuzz_host;
   import tlul_fuzz_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       cmd_valid;
   logic       cmd_ready;
   cmd_t       cmd_in;
   tl_h2d_t    h2d;
   tl_d2h_t    tl_in;
   logic       rsp_valid;
   logic       rsp_ready;
   rsp_t       rsp_out;
   logic [2:0] outstanding;
   logic [31:0] txn_cnt;
   logic       timeout;
   logic       proto_err;

   int tests = 0;
   int fails = 0;
   int a_fires = 0;
   logic [7:0]  a_src_log [64];
   logic [31:0] a_addr_log [64];

   tlul_fuzz_host dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .cmd_valid_i   (cmd_valid),
      .cmd_ready_o   (cmd_ready),
      .cmd_i         (cmd_in),
      .tl_o          (h2d),
      .tl_i          (tl_in),
      .rsp_valid_o   (rsp_valid),
      .rsp_ready_i   (rsp_ready),
      .rsp_o         (rsp_out),
      .outstanding_o (outstanding),
      .txn_cnt_o     (txn_cnt),
      .timeout_o     (timeout),
      .proto_err_o   (proto_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (rst_n && h2d.a_valid && tl_in.a_ready) begin
         a_src_log[a_fires[5:0]]  <= h2d.a_source;
         a_addr_log[a_fires[5:0]] <= h2d.a_address;
         a_fires                  <= a_fires + 1;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   task automatic push_cmd(input cmd_op_e op, input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] mask);
      int n = 0;
      cmd_valid   = 1'b1;
      cmd_in.op   = op;
      cmd_in.addr = addr;
      cmd_in.data = data;
      cmd_in.mask = mask;
      while (!cmd_ready && n < 200) begin tick(); n++; end
      chk("cmd_accept", 64'(cmd_ready), 64'd1);
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic wait_a(input string tag);
      int n = 0;
      while (!h2d.a_valid && n < 100) begin tick(); n++; end
      chk(tag, 64'(h2d.a_valid), 64'd1);
   endtask

   task automatic d_rsp(input logic [7:0] src, input logic [2:0] op, input logic [31:0] data);
      int n = 0;
      tl_in.d_valid  = 1'b1;
      tl_in.d_source = src;
      tl_in.d_opcode = op;
      tl_in.d_size   = 2'd2;
      tl_in.d_data   = data;
      tl_in.d_error  = 1'b0;
      while (!h2d.d_ready && n < 100) begin tick(); n++; end
      chk("d_accept", 64'(h2d.d_ready), 64'd1);
      tick();
      tl_in.d_valid = 1'b0;
   endtask

   task automatic pop_rsp(output rsp_t r);
      int n = 0;
      while (!rsp_valid && n < 100) begin tick(); n++; end
      chk("rsp_avail", 64'(rsp_valid), 64'd1);
      r = rsp_out;
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
   endtask

   initial begin
      rsp_t r;
      int   base;
      int   n;
      logic exp_perr;

      rst_n     = 1'b0;
      cmd_valid = 1'b0;
      cmd_in    = '0;
      tl_in     = '0;
      rsp_ready = 1'b0;
      tick(3);

      // Reset state
      chk("rst_a_valid",   64'(h2d.a_valid), 64'd0);
      chk("rst_d_ready",   64'(h2d.d_ready), 64'd0);
      chk("rst_cmd_ready", 64'(cmd_ready),   64'd0);
      chk("rst_rsp_valid", 64'(rsp_valid),   64'd0);
      chk("rst_outst",     64'(outstanding), 64'd0);
      chk("rst_txn",       64'(txn_cnt),     64'd0);
      chk("rst_timeout",   64'(timeout),     64'd0);
      chk("rst_proto",     64'(proto_err),   64'd0);
      rst_n = 1'b1;
      tick();
      chk("live_cmd_ready", 64'(cmd_ready),   64'd1);
      chk("live_d_ready",   64'(h2d.d_ready), 64'd1);
      tl_in.a_ready = 1'b1;

      // Single Get
      push_cmd(OpGet, 32'h10, 32'h0, 4'h0);
      wait_a("get_a_valid");
      chk("get_addr",   64'(h2d.a_address), 64'h10);
      chk("get_source", 64'(h2d.a_source),  64'd0);
      chk("get_opcode", 64'(h2d.a_opcode),  64'd4);
      chk("get_mask",   64'(h2d.a_mask),    64'hF);
      chk("get_size",   64'(h2d.a_size),    64'd2);
      tick();
      chk("get_outst", 64'(outstanding), 64'd1);
      d_rsp(8'd0, 3'd1, 32'hDEADBEEF);
      chk("get_rsp_valid", 64'(rsp_valid),   64'd1);
      chk("get_rsp",       64'(rsp_out),     {30'd0, 1'b0, 1'b1, 32'hDEADBEEF});
      chk("get_txn",       64'(txn_cnt),     64'd1);
      chk("get_outst0",    64'(outstanding), 64'd0);
      pop_rsp(r);

      // Six PutFull with D withheld: only four IDs exist
      base = a_fires;
      for (int i = 0; i < 6; i++) push_cmd(OpPutFull, 32'h100 + 32'(4 * i), 32'(i), 4'h0);
      tick(10);
      chk("put6_fires", 64'(a_fires - base), 64'd4);
      for (int i = 0; i < 4; i++) chk($sformatf("put6_src%0d", i), 64'(a_src_log[base + i]), 64'(i));
      chk("put6_outst",   64'(outstanding), 64'd4);
      chk("put6_a_valid", 64'(h2d.a_valid), 64'd0);
      d_rsp(8'd0, 3'd0, 32'h0);
      d_rsp(8'd1, 3'd0, 32'h0);
      tick(10);
      chk("put6_fires2", 64'(a_fires - base), 64'd6);
      chk("put6_reuse0", 64'(a_src_log[base + 4]), 64'd0);
      chk("put6_reuse1", 64'(a_src_log[base + 5]), 64'd1);
      chk("put6_addr5",  64'(a_addr_log[base + 5]), 64'h114);
      chk("put6_outst2", 64'(outstanding), 64'd4);
      pop_rsp(r);
      chk("put_rsp", 64'(r), 64'd0);
      pop_rsp(r);
      d_rsp(8'd2, 3'd0, 32'h0);
      d_rsp(8'd3, 3'd0, 32'h0);
      d_rsp(8'd0, 3'd0, 32'h0);
      d_rsp(8'd1, 3'd0, 32'h0);
      for (int i = 0; i < 4; i++) pop_rsp(r);
      chk("put6_txn",    64'(txn_cnt),     64'd7);
      chk("put6_outst0", 64'(outstanding), 64'd0);

      // PutFull ignores its mask; PutPartial with mask 0 becomes 4'h1, address word-aligned
      push_cmd(OpPutFull, 32'h203, 32'hA5A5A5A5, 4'h3);
      wait_a("pf_a_valid");
      chk("pf_mask",   64'(h2d.a_mask),    64'hF);
      chk("pf_opcode", 64'(h2d.a_opcode),  64'd0);
      chk("pf_addr",   64'(h2d.a_address), 64'h200);
      tick();
      d_rsp(8'd0, 3'd0, 32'h0);
      pop_rsp(r);
      push_cmd(OpPutPartial, 32'h7, 32'h12345678, 4'h0);
      wait_a("pp_a_valid");
      chk("pp_mask",   64'(h2d.a_mask),    64'h1);
      chk("pp_addr",   64'(h2d.a_address), 64'h4);
      chk("pp_opcode", 64'(h2d.a_opcode),  64'd1);
      chk("pp_data",   64'(h2d.a_data),    64'h12345678);
      tick();
      d_rsp(8'd0, 3'd0, 32'h0);
      pop_rsp(r);

      // Wait blocks until outstanding drains
      base = a_fires;
      push_cmd(OpGet, 32'h300, 32'h0, 4'h0);
      push_cmd(OpGet, 32'h304, 32'h0, 4'h0);
      push_cmd(OpWait, 32'h0, 32'd5, 4'h0);
      push_cmd(OpGet, 32'h40, 32'h0, 4'h0);
      tick(20);
      chk("wait_fires",   64'(a_fires - base), 64'd2);
      chk("wait_outst",   64'(outstanding),    64'd2);
      chk("wait_a_valid", 64'(h2d.a_valid),    64'd0);
      d_rsp(8'd0, 3'd1, 32'h11);
      d_rsp(8'd1, 3'd1, 32'h22);
      wait_a("wait_exit_a");
      chk("wait_next_addr", 64'(h2d.a_address), 64'h40);
      tick();
      d_rsp(8'd0, 3'd1, 32'h33);
      pop_rsp(r);
      chk("wait_rsp0", 64'(r), {30'd0, 1'b0, 1'b1, 32'h11});
      pop_rsp(r);
      pop_rsp(r);
      chk("wait_rsp2", 64'(r), {30'd0, 1'b0, 1'b1, 32'h33});

      // Wait of 5 cycles with nothing outstanding still delays the next request
      push_cmd(OpWait, 32'h0, 32'd5, 4'h0);
      push_cmd(OpGet, 32'h44, 32'h0, 4'h0);
      n = 0;
      while (!h2d.a_valid && n < 50) begin tick(); n++; end
      chk("wait5_a_valid", 64'(h2d.a_valid), 64'd1);
      chk("wait5_min_gap", 64'(n >= 5),      64'd1);
      tick();
      d_rsp(8'd0, 3'd1, 32'h44);
      pop_rsp(r);
      chk("wait_txn", 64'(txn_cnt), 64'd13);

      // Timeout: D withheld after one Get
      base = a_fires;
      push_cmd(OpGet, 32'h80, 32'h0, 4'h0);
      wait_a("to_a_valid");
      tick();
      n = 0;
      while (!timeout && n < 1200) begin tick(); n++; end
      chk("to_flag",  64'(timeout),                   64'd1);
      chk("to_delay", 64'((n >= 1020) && (n <= 1030)), 64'd1);
      push_cmd(OpPutFull, 32'h90, 32'h1, 4'h0);
      tick(10);
      chk("to_no_issue", 64'(a_fires - base), 64'd1);
      chk("to_a_valid",  64'(h2d.a_valid),    64'd0);
      chk("to_d_ready",  64'(h2d.d_ready),    64'd1);
      d_rsp(8'd0, 3'd1, 32'hCAFEF00D);
      chk("to_late_txn",   64'(txn_cnt),     64'd14);
      chk("to_late_outst", 64'(outstanding), 64'd0);
      pop_rsp(r);
      chk("to_late_rsp", 64'(r), {30'd0, 1'b0, 1'b1, 32'hCAFEF00D});
      tick(5);
      chk("to_sticky",    64'(timeout),          64'd1);
      chk("to_no_issue2", 64'(a_fires - base),   64'd1);

      // Reset mid-operation clears everything
      rst_n = 1'b0;
      tick();
      chk("rst2_timeout", 64'(timeout),     64'd0);
      chk("rst2_txn",     64'(txn_cnt),     64'd0);
      chk("rst2_outst",   64'(outstanding), 64'd0);
      rst_n = 1'b1;
      tick();

      // Unsolicited response on source 3 while idle
`ifdef TLUL_FUZZ_HOST_CHECK_EN
      exp_perr = 1'b1;
`else
      exp_perr = 1'b0;
`endif
      d_rsp(8'd3, 3'd0, 32'h55);
      chk("perr_flag", 64'(proto_err), 64'(exp_perr));
      pop_rsp(r);
      chk("perr_rsp_err", 64'(r.err), 64'(exp_perr));
      tick(3);
      chk("perr_sticky", 64'(proto_err), 64'(exp_perr));
      chk("perr_txn",    64'(txn_cnt),   64'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
